bnn_xnor_accumulator: RTL and testbench

- Parametrised successor of the single-word XNOR/popcount stage.
- Streams multi-beat binary dot products. Each beat XNORs a WL-bit activation word with a WL-bit weight word and masks off unused bits. The masked result is popcounted in a pipelined tree and accumulated across beats until the last beat of a neuron.
- On the last beat it emits:
  - the popcount total,
  - the signed dot product (2*pop - nbits),
  - a binary sign activation against a per-neuron threshold.
- Sits between the activation/weight buffers and the next BNN layer's input packer.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/bnn_xnor_accumulator_if.sv | 36 +++
 rtl/bnn_popcount_pipe.sv | 82 ++++++++
 rtl/bnn_xnor_accumulator.sv | 170 +++++++++++++++++
 tb/tb_bnn_xnor_accumulator.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and types for the binarised (XNOR/popcount) layer datapath.
package bnn_pkg;
    localparam int BNN_WL    = 112;
    localparam int BNN_ACC_W = 16;
    localparam int BNN_GRP   = 16;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int BNN_NGRP = ceil_div(BNN_WL, BNN_GRP);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } bnn_state_e;
endpackage

// File: rtl/bnn_xnor_accumulator_if.sv
// Beat input / result output bundle of the XNOR accumulator; master drives beats, slave is the accumulator.
interface bnn_xnor_accumulator_if
    import bnn_pkg::*;
#(
    parameter int WL    = BNN_WL,
    parameter int ACC_W = BNN_ACC_W,
    parameter int AW    = $clog2(WL)
);
    logic                    iEN;
    logic                    iFIRST;
    logic                    iLAST;
    logic                    iMODE;
    logic [AW-1:0]           iaddr;
    logic [WL-1:0]           idata;
    logic [WL-1:0]           iweight;
    logic [WL-1:0]           iMASK;
    logic signed [ACC_W:0]   iTHRESH;
    logic                    iCLR;

    logic [ACC_W-1:0]        odata;
    logic signed [ACC_W:0]   oDOT;
    logic                    oACT;
    logic                    oEN;
    logic                    oOVF;
    logic                    oERR;

    modport master (
        output iEN, iFIRST, iLAST, iMODE, iaddr, idata, iweight, iMASK, iTHRESH, iCLR,
        input  odata, oDOT, oACT, oEN, oOVF, oERR
    );

    modport slave (
        input  iEN, iFIRST, iLAST, iMODE, iaddr, idata, iweight, iMASK, iTHRESH, iCLR,
        output odata, oDOT, oACT, oEN, oOVF, oERR
    );
endinterface

// File: rtl/bnn_popcount_pipe.sv
// Two-stage pipelined popcount: input vector registered, then per-group counts registered; group sum is combinational.
// Latency: count for a vector presented at edge t is valid after edge t+1 (consumable at edge t+2).
// No backpressure: accepts one vector per cycle, sideband travels alongside the valid.
module bnn_popcount_pipe
    import bnn_pkg::*;
#(
    parameter int WL   = BNN_WL,
    parameter int GRP  = BNN_GRP,
    parameter int SB_W = 1,
    parameter int CW   = $clog2(WL + 1)
) (
    input  logic            iCLK,
    input  logic            iRSTn,
    input  logic            in_vld,
    input  logic [WL-1:0]   in_dat,
    input  logic [SB_W-1:0] in_sb,
    output logic            out_vld,
    output logic [CW-1:0]   out_dat,
    output logic [SB_W-1:0] out_sb
);
    localparam int NGRP = ceil_div(WL, GRP);
    localparam int GW   = $clog2(GRP + 1);

    logic                vld_a;
    logic                vld_b;
    logic [WL-1:0]       vec_a;
    logic [SB_W-1:0]     sb_a;
    logic [SB_W-1:0]     sb_b;
    logic [NGRP*GRP-1:0] vec_pad;
    logic [GW-1:0]       grp_d [NGRP];
    logic [GW-1:0]       grp_b [NGRP];

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            vld_a <= 1'b0;
            vec_a <= '0;
            sb_a  <= '0;
        end else begin
            vld_a <= in_vld;
            vec_a <= in_dat;
            sb_a  <= in_sb;
        end
    end

    // Last group is zero-padded when WL is not a multiple of GRP.
    always_comb begin
        vec_pad = '0;
        vec_pad[WL-1:0] = vec_a;
        for (int g = 0; g < NGRP; g++) begin
            grp_d[g] = '0;
            for (int b = 0; b < GRP; b++) begin
                grp_d[g] = grp_d[g] + GW'(vec_pad[g*GRP + b]);
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            vld_b <= 1'b0;
            sb_b  <= '0;
            for (int g = 0; g < NGRP; g++) begin
                grp_b[g] <= '0;
            end
        end else begin
            vld_b <= vld_a;
            sb_b  <= sb_a;
            for (int g = 0; g < NGRP; g++) begin
                grp_b[g] <= grp_d[g];
            end
        end
    end

    always_comb begin
        out_dat = '0;
        for (int g = 0; g < NGRP; g++) begin
            out_dat = out_dat + CW'(grp_b[g]);
        end
    end

    assign out_vld = vld_b;
    assign out_sb  = sb_b;
endmodule

// File: rtl/bnn_xnor_accumulator.sv
// Multi-beat binary dot product: XNOR + mask per beat, pipelined popcount, saturating accumulate, sign activation.
// Latency: last beat accepted at edge t updates results at edge t+2; oEN high for the following cycle.
// No backpressure: a beat is accepted on every edge with iEN=1, one beat per cycle sustained.
module bnn_xnor_accumulator
    import bnn_pkg::*;
#(
    parameter int WL    = BNN_WL,
    parameter int ACC_W = BNN_ACC_W,
    parameter int GRP   = BNN_GRP,
    parameter int AW    = $clog2(WL)
) (
    input  logic                         iCLK,
    input  logic                         iRSTn,
    bnn_xnor_accumulator_if.slave        bus
);
    localparam int CW = $clog2(WL + 1);
    localparam int SW = ACC_W + CW + 1;
    localparam logic [SW-1:0] SAT_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef struct packed {
        logic                  first;
        logic                  last;
        logic [CW-1:0]         nbits;
        logic signed [ACC_W:0] thresh;
    } beat_meta_t;

    logic [AW-1:0]         addr;
    logic                  addr_bad;
    logic                  addr_err;
    logic [WL-1:0]         xnor_vec;
    logic [WL-1:0]         x_vec;
    logic [CW-1:0]         nbits_in;
    beat_meta_t            meta_in;
    beat_meta_t            meta_s3;
    logic                  pp_vld;
    logic [CW-1:0]         pop_beat;

    bnn_state_e            state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d, nb_q, nb_d;
    logic signed [ACC_W:0] thr_q, thr_d, thr_use;
    logic [SW-1:0]         acc_raw, nb_raw;
    logic [ACC_W-1:0]      acc_new, nb_new;
    logic signed [ACC_W:0] dot_new;
    logic                  act_new;
    logic                  sat_hit;
    logic                  emit, frame_err, ovf_evt;

    logic [ACC_W-1:0]      odata_q;
    logic signed [ACC_W:0] dot_q;
    logic                  act_q, oen_q, ovf_q, err_q;

    assign addr     = bus.iaddr;
    assign addr_err = bus.iEN && addr_bad;

    always_comb begin
        xnor_vec = ~(bus.idata ^ bus.iweight);
        addr_bad = bus.iMODE && (int'(addr) >= WL);
        x_vec    = '0;
        nbits_in = '0;
        if (!bus.iMODE) begin
            x_vec = xnor_vec & bus.iMASK;
            for (int i = 0; i < WL; i++) begin
                nbits_in = nbits_in + CW'(bus.iMASK[i]);
            end
        end else if (!addr_bad) begin
            x_vec[addr] = xnor_vec[addr];
            nbits_in    = CW'(1);
        end
    end

    // The threshold rides with the beat so it is latched when the first beat reaches the FSM.
    always_comb begin
        meta_in.first  = bus.iFIRST;
        meta_in.last   = bus.iLAST;
        meta_in.nbits  = nbits_in;
        meta_in.thresh = bus.iTHRESH;
    end

    bnn_popcount_pipe #(
        .WL   (WL),
        .GRP  (GRP),
        .SB_W ($bits(beat_meta_t)),
        .CW   (CW)
    ) u_popcount_pipe (
        .iCLK    (iCLK),
        .iRSTn   (iRSTn),
        .in_vld  (bus.iEN),
        .in_dat  (x_vec),
        .in_sb   (meta_in),
        .out_vld (pp_vld),
        .out_dat (pop_beat),
        .out_sb  (meta_s3)
    );

    // A first beat restarts the sum even mid-neuron, so the old partial is never added in.
    always_comb begin
        acc_raw = SW'(pop_beat);
        nb_raw  = SW'(meta_s3.nbits);
        if (!meta_s3.first) begin
            acc_raw = acc_raw + SW'(acc_q);
            nb_raw  = nb_raw + SW'(nb_q);
        end
        sat_hit = (acc_raw > SAT_MAX) || (nb_raw > SAT_MAX);
        acc_new = (acc_raw > SAT_MAX) ? {ACC_W{1'b1}} : acc_raw[ACC_W-1:0];
        nb_new  = (nb_raw > SAT_MAX) ? {ACC_W{1'b1}} : nb_raw[ACC_W-1:0];
        thr_use = meta_s3.first ? meta_s3.thresh : thr_q;
        dot_new = {acc_new, 1'b0} - {1'b0, nb_new};
        act_new = (dot_new >= thr_use);
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        nb_d      = nb_q;
        thr_d     = thr_q;
        emit      = 1'b0;
        frame_err = 1'b0;
        ovf_evt   = 1'b0;
        if (pp_vld) begin
            if (meta_s3.first || (state_q == ACCUM)) begin
                frame_err = meta_s3.first && (state_q == ACCUM);
                acc_d     = acc_new;
                nb_d      = nb_new;
                ovf_evt   = sat_hit;
                if (meta_s3.first) begin
                    thr_d = meta_s3.thresh;
                end
                emit    = meta_s3.last;
                state_d = meta_s3.last ? IDLE : ACCUM;
            end else begin
                frame_err = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q <= IDLE;
            acc_q   <= '0;
            nb_q    <= '0;
            thr_q   <= '0;
            odata_q <= '0;
            dot_q   <= '0;
            act_q   <= 1'b0;
            oen_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            nb_q    <= nb_d;
            thr_q   <= thr_d;
            oen_q   <= emit;
            if (emit) begin
                odata_q <= acc_new;
                dot_q   <= dot_new;
                act_q   <= act_new;
            end
            ovf_q <= (ovf_q && !bus.iCLR) || ovf_evt;
            err_q <= (err_q && !bus.iCLR) || frame_err || addr_err;
        end
    end

    assign bus.odata = odata_q;
    assign bus.oDOT  = dot_q;
    assign bus.oACT  = act_q;
    assign bus.oEN   = oen_q;
    assign bus.oOVF  = ovf_q;
    assign bus.oERR  = err_q;
endmodule

// File: tb/tb_bnn_xnor_accumulator.sv
// Directed bench for the XNOR accumulator: default build plus an 8-bit accumulator build for saturation.
`timescale 1ns/1ps
module tb_bnn_xnor_accumulator;
    import bnn_pkg::*;

    localparam int WL = BNN_WL;
    localparam int AW = $clog2(WL);

    logic iCLK  = 1'b0;
    logic iRSTn = 1'b0;
    always #5 iCLK = ~iCLK;

    bnn_xnor_accumulator_if #(.WL(WL), .ACC_W(16), .AW(AW)) bus  ();
    bnn_xnor_accumulator_if #(.WL(WL), .ACC_W(8),  .AW(AW)) bus8 ();

    bnn_xnor_accumulator #(.WL(WL), .ACC_W(16), .GRP(16), .AW(AW)) dut (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .bus   (bus)
    );

    bnn_xnor_accumulator #(.WL(WL), .ACC_W(8), .GRP(16), .AW(AW)) dut8 (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .bus   (bus8)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [WL-1:0] low_mask(input int k);
        logic [WL-1:0] m;
        m = '0;
        for (int i = 0; i < k; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic beat(input logic first, input logic last, input logic mode,
                        input logic [AW-1:0] addr, input logic [WL-1:0] d,
                        input logic [WL-1:0] w, input logic [WL-1:0] m, input int thr);
        bus.iEN     = 1'b1;
        bus.iFIRST  = first;
        bus.iLAST   = last;
        bus.iMODE   = mode;
        bus.iaddr   = addr;
        bus.idata   = d;
        bus.iweight = w;
        bus.iMASK   = m;
        bus.iTHRESH = thr[16:0];
        bus.iCLR    = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic idle(input int n);
        bus.iEN    = 1'b0;
        bus.iFIRST = 1'b0;
        bus.iLAST  = 1'b0;
        bus.iCLR   = 1'b0;
        repeat (n) @(negedge iCLK);
    endtask

    task automatic clr_pulse();
        bus.iEN  = 1'b0;
        bus.iCLR = 1'b1;
        @(negedge iCLK);
        bus.iCLR = 1'b0;
    endtask

    task automatic beat8(input logic first, input logic last, input logic [WL-1:0] v);
        bus8.iEN     = 1'b1;
        bus8.iFIRST  = first;
        bus8.iLAST   = last;
        bus8.iMODE   = 1'b0;
        bus8.iaddr   = '0;
        bus8.idata   = v;
        bus8.iweight = v;
        bus8.iMASK   = '1;
        bus8.iTHRESH = '0;
        bus8.iCLR    = 1'b0;
        @(negedge iCLK);
        bus8.iEN    = 1'b0;
        bus8.iFIRST = 1'b0;
        bus8.iLAST  = 1'b0;
    endtask

    initial begin
        logic [WL-1:0] ones;
        logic [WL-1:0] pat;
        logic [WL-1:0] w37;
        int thr_tab[2];
        int act_tab[2];
        int seen;

        ones = '1;
        pat  = {4{28'hA5C3E1F}};
        w37  = ones;
        w37[37] = 1'b0;
        thr_tab = '{41, 40};
        act_tab = '{0, 1};

        bus.iEN = 0; bus.iFIRST = 0; bus.iLAST = 0; bus.iMODE = 0; bus.iaddr = '0;
        bus.idata = '0; bus.iweight = '0; bus.iMASK = '0; bus.iTHRESH = '0; bus.iCLR = 0;
        bus8.iEN = 0; bus8.iFIRST = 0; bus8.iLAST = 0; bus8.iMODE = 0; bus8.iaddr = '0;
        bus8.idata = '0; bus8.iweight = '0; bus8.iMASK = '0; bus8.iTHRESH = '0; bus8.iCLR = 0;

        // Reset state
        idle(2);
        check("rst_odata", bus.odata, 0);
        check("rst_odot",  bus.oDOT, 0);
        check("rst_oact",  bus.oACT, 0);
        check("rst_oen",   bus.oEN, 0);
        check("rst_oovf",  bus.oOVF, 0);
        check("rst_oerr",  bus.oERR, 0);
        iRSTn = 1'b1;
        idle(1);

        // Single-beat neuron, full match
        beat(1, 1, 0, '0, ones, ones, ones, 0);
        idle(1);
        check("t1_en_early", bus.oEN, 0);
        idle(1);
        check("t1_en",    bus.oEN, 1);
        check("t1_odata", bus.odata, 112);
        check("t1_odot",  bus.oDOT, 112);
        check("t1_oact",  bus.oACT, 1);
        idle(1);
        check("t1_en_drop", bus.oEN, 0);
        check("t1_hold",    bus.odata, 112);

        // Three-beat neuron; threshold only from the first beat
        for (int k = 0; k < 2; k++) begin
            beat(1, 0, 0, '0, ones, '0, ones, thr_tab[k]);
            beat(0, 0, 0, '0, pat, pat, ones, 0);
            beat(0, 1, 0, '0, pat, pat, low_mask(40), 0);
            idle(1);
            check("t2_en_mid", bus.oEN, 0);
            idle(1);
            check("t2_en",    bus.oEN, 1);
            check("t2_odata", bus.odata, 152);
            check("t2_odot",  bus.oDOT, 40);
            check("t2_oact",  bus.oACT, act_tab[k]);
        end

        // Back-to-back single-beat neurons
        for (int k = 5; k <= 7; k++) beat(1, 1, 0, '0, ones, ones, low_mask(k), 0);
        for (int k = 5; k <= 7; k++) begin
            check("t3_en",    bus.oEN, 1);
            check("t3_odata", bus.odata, k);
            idle(1);
        end
        check("t3_en_end", bus.oEN, 0);

        // Single-bit select, valid and out-of-range address
        beat(1, 1, 1, 7'd37, '0, w37, '0, 0);
        idle(2);
        check("t4_en",    bus.oEN, 1);
        check("t4_odata", bus.odata, 1);
        check("t4_odot",  bus.oDOT, 1);
        check("t4_oerr",  bus.oERR, 0);
        beat(1, 1, 1, 7'd120, '0, '0, ones, 0);
        idle(2);
        check("t4_bad_en",    bus.oEN, 1);
        check("t4_bad_odata", bus.odata, 0);
        check("t4_bad_odot",  bus.oDOT, 0);
        check("t4_bad_oerr",  bus.oERR, 1);
        clr_pulse();
        check("t4_clr", bus.oERR, 0);

        // Framing: beat without first while idle
        beat(0, 1, 0, '0, ones, ones, ones, 0);
        idle(1);
        check("t5_drop_en1", bus.oEN, 0);
        idle(1);
        check("t5_drop_en2", bus.oEN, 0);
        check("t5_drop_err", bus.oERR, 1);
        clr_pulse();
        check("t5_clr1", bus.oERR, 0);

        // Framing: first arrives mid-neuron
        beat(1, 0, 0, '0, ones, ones, low_mask(50), 0);
        beat(1, 1, 0, '0, ones, ones, low_mask(7), 0);
        idle(1);
        check("t5_restart_en_early", bus.oEN, 0);
        idle(1);
        check("t5_restart_en",    bus.oEN, 1);
        check("t5_restart_odata", bus.odata, 7);
        check("t5_restart_odot",  bus.oDOT, 7);
        check("t5_restart_err",   bus.oERR, 1);
        clr_pulse();
        check("t5_clr2", bus.oERR, 0);

        // Saturation on the 8-bit accumulator build
        beat8(1, 0, ones);
        beat8(0, 0, ones);
        beat8(0, 1, ones);
        idle(2);
        check("t6_en",    bus8.oEN, 1);
        check("t6_odata", bus8.odata, 255);
        check("t6_odot",  bus8.oDOT, 255);
        check("t6_oovf",  bus8.oOVF, 1);
        check("t6_main_ovf", bus.oOVF, 0);

        // Reset mid-neuron with a last beat in flight
        beat(1, 0, 0, '0, ones, ones, ones, 0);
        beat(0, 1, 0, '0, ones, ones, ones, 0);
        bus.iEN = 1'b0;
        iRSTn   = 1'b0;
        idle(1);
        check("t7_odata", bus.odata, 0);
        check("t7_odot",  bus.oDOT, 0);
        check("t7_oact",  bus.oACT, 0);
        check("t7_oen",   bus.oEN, 0);
        check("t7_ovf8",  bus8.oOVF, 0);
        iRSTn = 1'b1;
        seen = 0;
        repeat (5) begin
            idle(1);
            if (bus.oEN) seen++;
        end
        check("t7_no_stale_en", seen, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
